// File: rtl/hash_io_pkg.sv
// Shared types and constants for the hash host I/O controller.
package hash_io_pkg;

    localparam int DEF_IO_W     = 16;
    localparam int DEF_BLOCK_W  = 512;
    localparam int DEF_DIGEST_W = 256;
    localparam int DEF_TO_CYC   = 1024;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        HAND   = 3'd2,
        DIGEST = 3'd3,
        OUT    = 3'd4
    } hio_state_e;

    // Number of host words that make up a wider field.
    function automatic int words(input int w, input int io);
        return w / io;
    endfunction

endpackage

// File: rtl/hash_io_shreg.sv
// Word-wide shift register with parallel load; shifts towards the MSB end,
// new words enter at the LSB word. Parallel load wins over shift.
module hash_io_shreg #(
    parameter int W    = 512,
    parameter int IO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld,
    input  logic [W-1:0]    ld_data,
    input  logic            sh,
    input  logic [IO_W-1:0] sin,
    output logic [W-1:0]    q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] shifted;

    // Shifted value; a single-word register simply takes the incoming word.
    generate
        if (W > IO_W) begin : g_wide
            assign shifted = {q_q[W-IO_W-1:0], sin};
        end else begin : g_single
            assign shifted = sin;
        end
    endgenerate

    // Next value: load, shift or hold.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_data;
        end else if (sh) begin
            q_d = shifted;
        end
    end

    // Register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hash_io_ctrl.sv
// Host-side I/O controller for the hash cores: packs host words into message
// blocks and unpacks the digest on fetch.
// Optional: define HASH_IO_ERR_EN to build the sticky protocol-error flag and
// the core-wait timeout counter; otherwise err is tied low.
//
// state  | meaning
// IDLE   | after reset, waiting for init
// FILL   | collecting block words from the host
// HAND   | block offered to the core
// DIGEST | waiting for the core digest
// OUT    | digest words available to the host
module hash_io_ctrl
    import hash_io_pkg::*;
#(
    parameter int IO_W     = DEF_IO_W,
    parameter int BLOCK_W  = DEF_BLOCK_W,
    parameter int DIGEST_W = DEF_DIGEST_W,
    parameter int TO_CYC   = DEF_TO_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                load,
    input  logic                last,
    input  logic                fetch,
    input  logic [IO_W-1:0]     idata,
    output logic                ack,
    output logic [IO_W-1:0]     odata,
    output logic                err,
    output logic                core_init,
    output logic                core_blk_valid,
    output logic                core_blk_last,
    output logic [BLOCK_W-1:0]  core_blk,
    input  logic                core_blk_ready,
    input  logic                core_dgst_valid,
    input  logic [DIGEST_W-1:0] core_dgst
);

    localparam int NB   = words(BLOCK_W, IO_W);
    localparam int ND   = words(DIGEST_W, IO_W);
    localparam int NMAX = (NB > ND) ? ((NB > 2) ? NB : 2) : ((ND > 2) ? ND : 2);
    localparam int CW   = $clog2(NMAX);

    hio_state_e      state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            last_q, last_d;
    logic            ack_q, ack_d;
    logic            core_init_q, core_init_d;
    logic            blk_valid_q, blk_valid_d;
    logic            blk_last_q, blk_last_d;
    logic [IO_W-1:0] odata_q, odata_d;

    logic                blk_sh;
    logic                dg_ld;
    logic                dg_sh;
    logic [DIGEST_W-1:0] dg_q;

    // Block packing: words enter at the LSB end, so the first word ends at the MSBs.
    hash_io_shreg #(.W(BLOCK_W), .IO_W(IO_W)) u_blk_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (1'b0),
        .ld_data ('0),
        .sh      (blk_sh),
        .sin     (idata),
        .q       (core_blk)
    );

    // Digest unpacking: rotates, so after ND fetches the first word is on top again.
    hash_io_shreg #(.W(DIGEST_W), .IO_W(IO_W)) u_dg_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (dg_ld),
        .ld_data (core_dgst),
        .sh      (dg_sh),
        .sin     (dg_q[DIGEST_W-1 -: IO_W]),
        .q       (dg_q)
    );

    // Next-state and output logic; init overrides everything else.
    // Requiring ack_q low before an accept forces a gap cycle between acks.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        last_d      = last_q;
        ack_d       = 1'b0;
        core_init_d = 1'b0;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        odata_d     = odata_q;
        blk_sh      = 1'b0;
        dg_ld       = 1'b0;
        dg_sh       = 1'b0;
        if (init) begin
            core_init_d = 1'b1;
            wcnt_d      = '0;
            last_d      = 1'b0;
            blk_valid_d = 1'b0;
            blk_last_d  = 1'b0;
            state_d     = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (load && !ack_q) begin
                        ack_d  = 1'b1;
                        blk_sh = 1'b1;
                        if (wcnt_q == '0) begin
                            last_d = last;
                        end
                        if (wcnt_q == CW'(NB - 1)) begin
                            wcnt_d      = '0;
                            state_d     = HAND;
                            blk_valid_d = 1'b1;
                            blk_last_d  = (wcnt_q == '0) ? last : last_q;
                        end else begin
                            wcnt_d = wcnt_q + CW'(1);
                        end
                    end
                end
                HAND: begin
                    if (blk_valid_q && core_blk_ready) begin
                        blk_valid_d = 1'b0;
                        blk_last_d  = 1'b0;
                        state_d     = last_q ? DIGEST : FILL;
                    end
                end
                DIGEST: begin
                    if (core_dgst_valid) begin
                        dg_ld   = 1'b1;
                        wcnt_d  = '0;
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (fetch && !ack_q) begin
                        ack_d   = 1'b1;
                        dg_sh   = 1'b1;
                        odata_d = dg_q[DIGEST_W-1 -: IO_W];
                        wcnt_d  = (wcnt_q == CW'(ND - 1)) ? '0 : wcnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            last_q      <= 1'b0;
            ack_q       <= 1'b0;
            core_init_q <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            odata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            last_q      <= last_d;
            ack_q       <= ack_d;
            core_init_q <= core_init_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            odata_q     <= odata_d;
        end
    end

    assign ack            = ack_q;
    assign odata          = odata_q;
    assign core_init      = core_init_q;
    assign core_blk_valid = blk_valid_q;
    assign core_blk_last  = blk_last_q;

`ifdef HASH_IO_ERR_EN
    localparam int TW = $clog2(TO_CYC + 1);

    logic          err_q, err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_run;

    // Error detection; the timeout down-counter reloads on every state change
    // so HAND and DIGEST are timed separately. A mid-block init sets err even
    // though init otherwise clears it.
    always_comb begin
        err_d    = err_q;
        to_run   = (state_q == HAND) || (state_q == DIGEST);
        to_cnt_d = to_cnt_q;
        if (!to_run || (state_d != state_q)) begin
            to_cnt_d = TW'(TO_CYC);
        end else if (to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - TW'(1);
        end
        if (init) begin
            err_d = (state_q == FILL) && (wcnt_q != '0);
        end else begin
            if (load && (state_q inside {HAND, DIGEST, OUT})) begin
                err_d = 1'b1;
            end
            if (fetch && (state_q inside {FILL, HAND, DIGEST})) begin
                err_d = 1'b1;
            end
            if (to_run && (to_cnt_q == '0)) begin
                err_d = 1'b1;
            end
        end
    end

    // Error flag and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            to_cnt_q <= TW'(TO_CYC);
        end else begin
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign err = err_q;
`else
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
    assign err = 1'b0;
`endif

endmodule
